// File: rtl/ctrl_seq_pkg.sv
// ctrl_seq shared definitions: opcode field values and sequencer states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ctrl_seq_pkg;

  // Opcode field values, matched against the top bits of the instruction
  localparam logic [4:0] kLOAD   = 5'b11010;  // [8:4]
  localparam logic [4:0] kSTORE  = 5'b11011;  // [8:4]
  localparam logic [3:0] kCMP    = 4'b1110;   // [8:5]
  localparam logic [3:0] kBRANCH = 4'b1111;   // [8:5]
  localparam logic [8:0] kHALT   = 9'h1FF;    // whole 9-bit word

  // Width of the load-latency down-counter (MEM_LAT is 0..7)
  localparam int WAIT_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    LOAD_WAIT,
    SQUASH,
    HALT
  } ctrl_state_t;

endpackage

// File: rtl/ctrl_seq_if.sv
// Instruction/flag inputs and PC/regfile/memory controls of the sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; the sequencer stalls the PC itself through PcEn.
interface ctrl_seq_if #(
  parameter int IW   = 9,
  parameter int TW   = 5,
  parameter int CNTW = 16
);
  logic            Start;
  logic [IW-1:0]   Instruction;
  logic            ZeroFlag;
  logic            PcEn;
  logic            Jump;
  logic [TW-1:0]   PCTargIdx;
  logic            RegWrEn;
  logic            MemWrEn;
  logic            LoadInst;
  logic            Ack;
  logic            Busy;
  logic [CNTW-1:0] InstrCount;

  // Sequencer side
  modport slave (
    input  Start, Instruction, ZeroFlag,
    output PcEn, Jump, PCTargIdx, RegWrEn, MemWrEn, LoadInst, Ack, Busy, InstrCount
  );

  // Fetch/environment side
  modport master (
    output Start, Instruction, ZeroFlag,
    input  PcEn, Jump, PCTargIdx, RegWrEn, MemWrEn, LoadInst, Ack, Busy, InstrCount
  );
endinterface

// File: rtl/ctrl_seq_decode.sv
// Pure combinational instruction classifier; exactly one class is active.
// Latency: 0 cycles.
// Backpressure: none.
module ctrl_seq_decode
  import ctrl_seq_pkg::*;
#(
  parameter int IW = 9
) (
  input  logic [IW-1:0] instr_i,
  output logic          is_load_o,
  output logic          is_store_o,
  output logic          is_cmp_o,
  output logic          is_branch_o,
  output logic          is_halt_o,
  output logic          is_alu_o
);

  logic [4:0] op5;
  logic [3:0] op4;
  logic [2:0] op3;

  assign op5 = instr_i[IW-1 -: 5];
  assign op4 = instr_i[IW-1 -: 4];
  assign op3 = instr_i[IW-1 -: 3];

  // HALT shares the BRANCH prefix, so it is carved out of the branch class
  always_comb begin
    is_halt_o   = (instr_i[IW-1 -: 9] == kHALT) && (&instr_i);
    is_load_o   = (op5 == kLOAD);
    is_store_o  = (op5 == kSTORE);
    is_cmp_o    = (op4 == kCMP);
    is_branch_o = (op4 == kBRANCH) && !is_halt_o;
    is_alu_o    = (op3 != 3'b111) && !is_load_o && !is_store_o;
  end

endmodule

// File: rtl/ctrl_seq.sv
// Run/halt sequencer: decodes instructions into PC/regfile/memory controls.
// Latency: controls combinational from Instruction and state; load takes MEM_LAT+1 cycles.
// Backpressure: holds PcEn low during load waits so the instruction stays stable.
module ctrl_seq
  import ctrl_seq_pkg::*;
#(
  parameter int IW      = 9,
  parameter int MEM_LAT = 2,
  parameter int TW      = 5,
  parameter int CNTW    = 16
) (
  input  logic     Clk,
  input  logic     Reset,
  ctrl_seq_if.slave bus
);

  ctrl_state_t       state_q, state_d;
  logic              cond_q, cond_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              ack_q;
  logic [CNTW-1:0]   cnt_q, cnt_d;

  logic            is_load, is_store, is_cmp, is_branch, is_halt, is_alu;
  logic            retire;
  logic            pc_en, jump, reg_wr, mem_wr, load_inst;
  logic [TW-1:0]   targ;

  ctrl_seq_decode #(.IW(IW)) u_decode (
    .instr_i     (bus.Instruction),
    .is_load_o   (is_load),
    .is_store_o  (is_store),
    .is_cmp_o    (is_cmp),
    .is_branch_o (is_branch),
    .is_halt_o   (is_halt),
    .is_alu_o    (is_alu)
  );

  // Next state, compare flag, wait counter, retire count and decoded controls
  always_comb begin
    state_d   = state_q;
    cond_d    = cond_q;
    wait_d    = wait_q;
    cnt_d     = cnt_q;
    retire    = 1'b0;
    pc_en     = 1'b0;
    jump      = 1'b0;
    targ      = '0;
    reg_wr    = 1'b0;
    mem_wr    = 1'b0;
    load_inst = 1'b0;

    case (state_q)
      IDLE, HALT: begin
        if (bus.Start) begin
          state_d = RUN;
          cnt_d   = '0;
          cond_d  = 1'b0;
        end
      end
      RUN: begin
        pc_en = 1'b1;
        if (is_halt) begin
          pc_en   = 1'b0;
          retire  = 1'b1;
          state_d = HALT;
        end else if (is_load) begin
          load_inst = 1'b1;
          if (MEM_LAT == 0) begin
            reg_wr = 1'b1;
            retire = 1'b1;
          end else begin
            // Freeze the PC so the load stays on Instruction while data arrives
            pc_en   = 1'b0;
            wait_d  = WAIT_W'(MEM_LAT);
            state_d = LOAD_WAIT;
          end
        end else if (is_store) begin
          mem_wr = 1'b1;
          retire = 1'b1;
        end else if (is_cmp) begin
          cond_d = bus.ZeroFlag;
          retire = 1'b1;
        end else if (is_branch) begin
          targ   = bus.Instruction[TW-1:0];
          retire = 1'b1;
          if (cond_q) begin
            jump    = 1'b1;
            state_d = SQUASH;
          end
        end else if (is_alu) begin
          reg_wr = 1'b1;
          retire = 1'b1;
        end
      end
      LOAD_WAIT: begin
        load_inst = 1'b1;
        wait_d    = wait_q - 1'b1;
        if (wait_q == WAIT_W'(1)) begin
          reg_wr  = 1'b1;
          pc_en   = 1'b1;
          retire  = 1'b1;
          state_d = RUN;
        end
      end
      SQUASH: begin
        // The fall-through instruction fetched behind a taken branch is dropped
        pc_en   = 1'b1;
        state_d = RUN;
      end
      default: state_d = IDLE;
    endcase

    if (retire && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  // State and counters; reset takes priority over Start
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      cond_q  <= 1'b0;
      wait_q  <= '0;
      ack_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cond_q  <= cond_d;
      wait_q  <= wait_d;
      ack_q   <= (state_d == HALT);
      cnt_q   <= cnt_d;
    end
  end

  // Controls are squelched while reset is held so an interrupted load never writes
  assign bus.PcEn       = Reset & pc_en;
  assign bus.Jump       = Reset & jump;
  assign bus.PCTargIdx  = Reset ? targ : '0;
  assign bus.RegWrEn    = Reset & reg_wr;
  assign bus.MemWrEn    = Reset & mem_wr;
  assign bus.LoadInst   = Reset & load_inst;
  assign bus.Ack        = ack_q;
  assign bus.Busy       = (state_q == RUN) || (state_q == LOAD_WAIT) || (state_q == SQUASH);
  assign bus.InstrCount = cnt_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// Scoreboard bench for ctrl_seq: per-cycle expected outputs queued and compared.
// Latency: inputs change 1ns after the rising edge, outputs sampled on the falling edge.
// Backpressure: n/a.
module tb_ctrl_seq;

  localparam int CNTW = 8;
  localparam logic [8:0] ALU   = 9'b0_0100_0001;
  localparam logic [8:0] STORE = 9'b1_1011_0000;
  localparam logic [8:0] LOAD  = 9'b1_1010_0011;
  localparam logic [8:0] CMP   = 9'b1_1100_0000;
  localparam logic [8:0] BR    = 9'b1_1110_0101;
  localparam logic [8:0] HLT   = 9'b1_1111_1111;

  typedef struct packed {
    logic            pc_en;
    logic            jump;
    logic [4:0]      targ;
    logic            reg_wr;
    logic            mem_wr;
    logic            load_inst;
    logic            ack;
    logic            busy;
    logic [CNTW-1:0] cnt;
  } obs_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  obs_t sb[$];

  ctrl_seq_if #(.IW(9), .TW(5), .CNTW(CNTW)) bus ();

  ctrl_seq #(.IW(9), .MEM_LAT(2), .TW(5), .CNTW(CNTW)) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(input logic pc, input logic j, input logic [4:0] t,
                              input logic rw, input logic mw, input logic li,
                              input logic ak, input logic bz, input logic [CNTW-1:0] c);
    return {pc, j, t, rw, mw, li, ak, bz, c};
  endfunction

  function automatic obs_t observe();
    return {bus.PcEn, bus.Jump, bus.PCTargIdx, bus.RegWrEn, bus.MemWrEn,
            bus.LoadInst, bus.Ack, bus.Busy, bus.InstrCount};
  endfunction

  task automatic drive(input logic r, input logic s, input logic [8:0] ins, input logic zf);
    @(posedge clk);
    #1;
    rst_n           = r;
    bus.Start       = s;
    bus.Instruction = ins;
    bus.ZeroFlag    = zf;
  endtask

  task automatic test_reset();
    obs_t e, o;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0, 1: drive(1'b0, 1'b0, ALU, 1'b0);
        default: drive(1'b1, 1'b0, ALU, 1'b0);
      endcase
      sb.push_back(mk(0, 0, 5'd0, 0, 0, 0, 0, 0, 8'd0));
      @(negedge clk);
      e = sb.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset row %0d: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_alu_store();
    obs_t e, o;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin drive(1, 1, ALU, 0);   sb.push_back(mk(0, 0, 5'd0, 0, 0, 0, 0, 0, 8'd0)); end
        1: begin drive(1, 0, ALU, 0);   sb.push_back(mk(1, 0, 5'd0, 1, 0, 0, 0, 1, 8'd0)); end
        2: begin drive(1, 0, STORE, 0); sb.push_back(mk(1, 0, 5'd0, 0, 1, 0, 0, 1, 8'd1)); end
        default: begin drive(1, 1, ALU, 0); sb.push_back(mk(1, 0, 5'd0, 1, 0, 0, 0, 1, 8'd2)); end
      endcase
      @(negedge clk);
      e = sb.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL alu_store row %0d: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_load();
    obs_t e, o;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin drive(1, 0, LOAD, 0); sb.push_back(mk(0, 0, 5'd0, 0, 0, 1, 0, 1, 8'd3)); end
        1: begin drive(1, 0, LOAD, 0); sb.push_back(mk(0, 0, 5'd0, 0, 0, 1, 0, 1, 8'd3)); end
        2: begin drive(1, 0, LOAD, 0); sb.push_back(mk(1, 0, 5'd0, 1, 0, 1, 0, 1, 8'd3)); end
        default: begin drive(1, 0, ALU, 0); sb.push_back(mk(1, 0, 5'd0, 1, 0, 0, 0, 1, 8'd4)); end
      endcase
      @(negedge clk);
      e = sb.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL load row %0d: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_branch();
    obs_t e, o;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: begin drive(1, 0, CMP, 1); sb.push_back(mk(1, 0, 5'd0, 0, 0, 0, 0, 1, 8'd5)); end
        1: begin drive(1, 0, BR, 0);  sb.push_back(mk(1, 1, 5'd5, 0, 0, 0, 0, 1, 8'd6)); end
        2: begin drive(1, 0, ALU, 0); sb.push_back(mk(1, 0, 5'd0, 0, 0, 0, 0, 1, 8'd7)); end
        3: begin drive(1, 0, CMP, 0); sb.push_back(mk(1, 0, 5'd0, 0, 0, 0, 0, 1, 8'd7)); end
        4: begin drive(1, 0, BR, 1);  sb.push_back(mk(1, 0, 5'd5, 0, 0, 0, 0, 1, 8'd8)); end
        default: begin drive(1, 0, ALU, 0); sb.push_back(mk(1, 0, 5'd0, 1, 0, 0, 0, 1, 8'd9)); end
      endcase
      @(negedge clk);
      e = sb.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL branch row %0d: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_halt();
    obs_t e, o;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin drive(1, 0, HLT, 0); sb.push_back(mk(0, 0, 5'd0, 0, 0, 0, 0, 1, 8'd10)); end
        1: begin drive(1, 0, ALU, 0); sb.push_back(mk(0, 0, 5'd0, 0, 0, 0, 1, 0, 8'd11)); end
        2: begin drive(1, 1, ALU, 0); sb.push_back(mk(0, 0, 5'd0, 0, 0, 0, 1, 0, 8'd11)); end
        default: begin drive(1, 0, ALU, 0); sb.push_back(mk(1, 0, 5'd0, 1, 0, 0, 0, 1, 8'd0)); end
      endcase
      @(negedge clk);
      e = sb.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL halt row %0d: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    obs_t e, o;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: begin drive(1, 0, LOAD, 0); sb.push_back(mk(0, 0, 5'd0, 0, 0, 1, 0, 1, 8'd1)); end
        1: begin drive(1, 0, LOAD, 0); sb.push_back(mk(0, 0, 5'd0, 0, 0, 1, 0, 1, 8'd1)); end
        2: begin drive(0, 0, LOAD, 0); sb.push_back(mk(0, 0, 5'd0, 0, 0, 0, 0, 1, 8'd1)); end
        3: begin drive(1, 0, LOAD, 0); sb.push_back(mk(0, 0, 5'd0, 0, 0, 0, 0, 0, 8'd0)); end
        4: begin drive(0, 1, ALU, 0);  sb.push_back(mk(0, 0, 5'd0, 0, 0, 0, 0, 0, 8'd0)); end
        default: begin drive(1, 0, ALU, 0); sb.push_back(mk(0, 0, 5'd0, 0, 0, 0, 0, 0, 8'd0)); end
      endcase
      @(negedge clk);
      e = sb.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_mid_load row %0d: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_saturate();
    obs_t e, o;
    int   c;
    for (int i = 0; i < 258; i++) begin
      if (i == 0) begin
        drive(1, 1, ALU, 0);
        sb.push_back(mk(0, 0, 5'd0, 0, 0, 0, 0, 0, 8'd0));
      end else begin
        drive(1, 0, ALU, 0);
        c = (i - 1 > 255) ? 255 : i - 1;
        sb.push_back(mk(1, 0, 5'd0, 1, 0, 0, 0, 1, CNTW'(c)));
      end
      @(negedge clk);
      e = sb.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL saturate row %0d: got %h expected %h", i, o, e);
      end
    end
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst_n           = 1'b0;
    bus.Start       = 1'b0;
    bus.Instruction = '0;
    bus.ZeroFlag    = 1'b0;
    test_reset();
    test_alu_store();
    test_load();
    test_branch();
    test_halt();
    test_reset_mid_load();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
